// File: rtl/rand_rot_scheduler.sv
// Randomness scheduler. Each fresh PRNG word is served NUM_USE times, and each use is rotated right by ROT bits from the one before.
// Optional one-word prefetch buffer, enabled with `define RAND_PREFETCH_EN, removes the bubble between words.
`timescale 1ns/1ps
module rand_rot_scheduler #(
   parameter int WIDTH   = 144,
   parameter int ROT     = 9,
   parameter int NUM_USE = 8,
   localparam int IDX_W  = (NUM_USE > 1) ? $clog2(NUM_USE) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rnd_in,
   input  logic             rnd_in_valid,
   output logic             rnd_in_ready,
   output logic [WIDTH-1:0] rnd_out,
   output logic             rnd_out_valid,
   input  logic             rnd_out_ready,
   output logic [IDX_W-1:0] use_idx,
   output logic             last_use
);

   localparam logic [0:0]       S_EMPTY  = 1'b0;
   localparam logic [0:0]       S_SERVE  = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_USE - 1);

   logic [0:0] state;
   logic       in_fire, out_fire, retire;

   assign rnd_out_valid = (state == S_SERVE);
   assign last_use      = rnd_out_valid && (use_idx == LAST_IDX);
   assign in_fire       = rnd_in_valid && rnd_in_ready;
   assign out_fire      = rnd_out_valid && rnd_out_ready;
   assign retire        = out_fire && (use_idx == LAST_IDX);

`ifdef RAND_PREFETCH_EN
   logic [WIDTH-1:0] buffer;
   logic             buf_valid;

   assign rnd_in_ready = !buf_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_EMPTY;
         rnd_out   <= '0;
         use_idx   <= '0;
         buffer    <= '0;
         buf_valid <= 1'b0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (in_fire) begin
                  rnd_out <= rnd_in;
                  use_idx <= '0;
                  state   <= S_SERVE;
               end
            end
            default: begin
               if (retire) begin
                  use_idx <= '0;
                  // Buffered word wins; ready is low while it is held, so no in_fire can collide.
                  if (buf_valid) begin
                     rnd_out   <= buffer;
                     buf_valid <= 1'b0;
                  end else if (in_fire) begin
                     rnd_out <= rnd_in;
                  end else begin
                     state <= S_EMPTY;
                  end
               end else begin
                  if (out_fire) begin
                     rnd_out <= {rnd_out[ROT-1:0], rnd_out[WIDTH-1:ROT]};
                     use_idx <= use_idx + IDX_W'(1);
                  end
                  if (in_fire) begin
                     buffer    <= rnd_in;
                     buf_valid <= 1'b1;
                  end
               end
            end
         endcase
      end
   end
`else
   assign rnd_in_ready = (state == S_EMPTY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_EMPTY;
         rnd_out <= '0;
         use_idx <= '0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (in_fire) begin
                  rnd_out <= rnd_in;
                  use_idx <= '0;
                  state   <= S_SERVE;
               end
            end
            default: begin
               if (retire) begin
                  use_idx <= '0;
                  state   <= S_EMPTY;
               end else if (out_fire) begin
                  rnd_out <= {rnd_out[ROT-1:0], rnd_out[WIDTH-1:ROT]};
                  use_idx <= use_idx + IDX_W'(1);
               end
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_rand_rot_scheduler.sv
// Scoreboard bench for rand_rot_scheduler. It uses an 8-use instance and a single-use instance.
// The driver pushes the expected uses at every in_fire. The monitors pop and compare them on each out_fire.
`timescale 1ns/1ps
module tb_rand_rot_scheduler;
   localparam int W  = 144;
   localparam int R  = 9;
   localparam int NU = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  rnd_in, rnd_out;
   logic          rnd_in_valid, rnd_in_ready, rnd_out_valid, rnd_out_ready, last_use;
   logic [2:0]    use_idx;
   logic [W-1:0]  rnd_in1, rnd_out1;
   logic          rnd_in_valid1, rnd_in_ready1, rnd_out_valid1, rnd_out_ready1, last_use1;
   logic [0:0]    use_idx1;

   typedef struct {logic [W-1:0] d; int idx; logic last;} exp_t;
   exp_t q0[$], q1[$];
   exp_t e0, e1;
   int   n_chk = 0, n_pass = 0;

   localparam logic [W-1:0] W1 = 144'h1FF;
   localparam logic [W-1:0] W1_IDX1 = 144'hFF8_00000000_00000000_00000000_00000000_0;
   localparam logic [W-1:0] WA = 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5A5;
   localparam logic [W-1:0] WB = 144'hDEAD_BEEF_0000_1111_2222_3333_4444_5555_C3C3;
   localparam logic [W-1:0] WC = 144'h8000_0000_0000_0000_0000_0000_0000_0000_0001;

   always #5 clk = ~clk;

   rand_rot_scheduler #(.WIDTH(W), .ROT(R), .NUM_USE(NU)) u_dut (
      .clk(clk), .rst(rst), .rnd_in(rnd_in), .rnd_in_valid(rnd_in_valid),
      .rnd_in_ready(rnd_in_ready), .rnd_out(rnd_out), .rnd_out_valid(rnd_out_valid),
      .rnd_out_ready(rnd_out_ready), .use_idx(use_idx), .last_use(last_use));

   rand_rot_scheduler #(.WIDTH(W), .ROT(R), .NUM_USE(1)) u_dut1 (
      .clk(clk), .rst(rst), .rnd_in(rnd_in1), .rnd_in_valid(rnd_in_valid1),
      .rnd_in_ready(rnd_in_ready1), .rnd_out(rnd_out1), .rnd_out_valid(rnd_out_valid1),
      .rnd_out_ready(rnd_out_ready1), .use_idx(use_idx1), .last_use(last_use1));

   function automatic logic [W-1:0] rotr(input logic [W-1:0] w, input int s);
      logic [2*W-1:0] d;
      d = {w, w} >> (s % W);
      return d[W-1:0];
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic fail_now(input string nm);
      n_chk++;
      $display("FAIL %s: bound expired", nm);
   endtask

   always @(negedge clk) begin
      if (!rst && rnd_out_valid && rnd_out_ready) begin
         if (q0.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out: got %h idx %0d expected no output", rnd_out, use_idx);
         end else begin
            e0 = q0.pop_front();
            chk("out_data", rnd_out, e0.d);
            chk("out_idx", W'(use_idx), W'(e0.idx));
            chk("out_last", W'(last_use), W'(e0.last));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rnd_out_valid1 && rnd_out_ready1) begin
         if (q1.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out1: got %h expected no output", rnd_out1);
         end else begin
            e1 = q1.pop_front();
            chk("out1_data", rnd_out1, e1.d);
            chk("out1_idx", W'(use_idx1), W'(e1.idx));
            chk("out1_last", W'(last_use1), W'(e1.last));
         end
      end
   end

   task automatic send_word(input logic [W-1:0] w);
      int n = 0;
      rnd_in = w;
      rnd_in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (rnd_in_ready) break;
         n++;
         if (n > 200) begin
            fail_now("send_word_ready");
            rnd_in_valid = 1'b0;
            return;
         end
      end
      for (int k = 0; k < NU; k++) q0.push_back('{rotr(w, k * R), k, k == NU - 1});
      @(posedge clk); #1;
      rnd_in_valid = 1'b0;
   endtask

   task automatic send_word1(input logic [W-1:0] w);
      int n = 0;
      rnd_in1 = w;
      rnd_in_valid1 = 1'b1;
      forever begin
         @(negedge clk);
         if (rnd_in_ready1) break;
         n++;
         if (n > 200) begin
            fail_now("send_word1_ready");
            rnd_in_valid1 = 1'b0;
            return;
         end
      end
      q1.push_back('{w, 0, 1'b1});
      @(posedge clk); #1;
      rnd_in_valid1 = 1'b0;
   endtask

   task automatic drain0();
      int n = 0;
      while (q0.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            fail_now("drain0");
            q0.delete();
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic drain1();
      int n = 0;
      while (q1.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            fail_now("drain1");
            q1.delete();
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rnd_in = '0; rnd_in_valid = 1'b0; rnd_out_ready = 1'b0;
      rnd_in1 = '0; rnd_in_valid1 = 1'b0; rnd_out_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", rnd_out, '0);
      chk("rst_valid", W'(rnd_out_valid), '0);
      chk("rst_idx", W'(use_idx), '0);
      chk("rst_last", W'(last_use), '0);
      chk("rst_valid1", W'(rnd_out_valid1), '0);
      rst = 1'b0;
      #1 chk("empty_in_ready", W'(rnd_in_ready), W'(1));

      // Single bit group, consumer always ready: latency and first rotation
      rnd_out_ready = 1'b1;
      send_word(W1);
      chk("lat_valid", W'(rnd_out_valid), W'(1));
      chk("lat_idx", W'(use_idx), '0);
      chk("lat_data", rnd_out, W1);
      @(posedge clk); #1;
      chk("idx1_idx", W'(use_idx), W'(1));
      chk("idx1_data", rnd_out, W1_IDX1);
      drain0();
      chk("idle_valid", W'(rnd_out_valid), '0);

      // Consumer stalls three cycles at idx3
      rnd_out_ready = 1'b0;
      send_word(WA);
      rnd_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rnd_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_idx", W'(use_idx), W'(3));
         chk("stall_data", rnd_out, rotr(WA, 27));
         chk("stall_valid", W'(rnd_out_valid), W'(1));
      end
      @(posedge clk); #1 rnd_out_ready = 1'b1;
      drain0();

      // PRNG always valid, consumer always ready: valid pattern and word order
      fork
         begin
            send_word(WA);
            send_word(WB);
            send_word(WC);
         end
         begin
            int n = 0;
            int nsamp;
            logic ev;
            while (!rnd_out_valid && n < 50) begin @(negedge clk); n++; end
            if (!rnd_out_valid) fail_now("stream_start");
`ifdef RAND_PREFETCH_EN
            nsamp = 24;
`else
            nsamp = 26;
`endif
            for (int i = 0; i < nsamp; i++) begin
`ifdef RAND_PREFETCH_EN
               ev = 1'b1;
`else
               ev = (i % 9) != 8;
               chk("stream_in_ready", W'(rnd_in_ready), W'(!ev));
`endif
               chk("stream_valid", W'(rnd_out_valid), W'(ev));
               @(negedge clk);
            end
         end
      join
      drain0();
      chk("stream_idle", W'(rnd_out_valid), '0);

      // Reset asserted mid-word at idx5
      send_word(WB);
      begin
         int n = 0;
         while (use_idx != 3'd5 && n < 50) begin @(negedge clk); n++; end
         if (use_idx != 3'd5) fail_now("wait_idx5");
      end
      rst = 1'b1;
      #1;
      chk("midrst_out", rnd_out, '0);
      chk("midrst_valid", W'(rnd_out_valid), '0);
      chk("midrst_idx", W'(use_idx), '0);
      q0.delete();
      @(posedge clk); #1 rst = 1'b0;
      send_word(WC);
      chk("after_rst_idx", W'(use_idx), '0);
      chk("after_rst_data", rnd_out, WC);
      drain0();
      chk("after_rst_idle", W'(rnd_out_valid), '0);

      // Single-use instance: each word appears once, unrotated
      rnd_out_ready1 = 1'b1;
      send_word1(WA);
      send_word1(WB);
      send_word1(W1);
      drain1();
      chk("single_idle", W'(rnd_out_valid1), '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
